// File: rtl/theremin_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : theremin_pkg
//  Purpose  : Shared widths and types for the theremin pitch-measurement path.
//             Holds the default fixed-point widths of the period word and the
//             period meter state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package theremin_pkg;

   // Integer bits of a period word, in CLK cycles
   localparam int PERIOD_INT_PART_DEF  = 10;
   // Fraction bits of a period word
   localparam int PERIOD_FRAC_PART_DEF = 20;
   // Sub-cycle resolution of a sensor edge position
   localparam int EDGE_FRAC_BITS_DEF   = 3;

   // Period meter operating state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no signal, waiting for the first edge
      ST_FILL = 2'd1,   // collecting the first window of timestamps
      ST_RUN  = 2'd2    // window full, one averaged period per edge
   } meter_state_t;

endpackage : theremin_pkg
`default_nettype wire

// File: rtl/edge_timestamp_ring.sv
`default_nettype none
// ============================================================================
//  Module   : edge_timestamp_ring
//  Purpose  : Ring buffer of 2^DEPTH_LOG2 edge timestamps with a single write
//             pointer. The entry under the pointer is always the oldest one,
//             so it is presented combinationally and overwritten on the next
//             write.
//  Revision : 1.0  initial release
// ============================================================================
module edge_timestamp_ring
   import theremin_pkg::*;
#(
   parameter int TS_WIDTH   = 18,
   parameter int DEPTH_LOG2 = 4
)(
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                wr_en,
   input  logic [TS_WIDTH-1:0] wr_data,
   output logic [TS_WIDTH-1:0] oldest
);

   localparam int c_depth = 1 << DEPTH_LOG2;

   logic [TS_WIDTH-1:0]   r_mem [c_depth];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;

   // Storage array: contents are only meaningful once the owner has filled it
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Write pointer wraps naturally across the power-of-two depth
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_ptr <= '0;
      end else if (wr_en) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   assign oldest = r_mem[r_wr_ptr];

endmodule : edge_timestamp_ring
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : period_meter
//  Purpose  : Measures the sensor oscillator period as a moving average over
//             2^AVG_SHIFT periods with sub-cycle edge resolution, producing a
//             fixed-point period word for the downstream oscillator.
//             Optional build macro PERIOD_METER_GLITCH_REJECT_EN drops edges
//             arriving less than MIN_EDGE_CYCLES cycles after the last
//             accepted edge.
//  Revision : 1.0  initial release
// ============================================================================
module period_meter
   import theremin_pkg::*;
#(
   parameter int PERIOD_INT_PART  = PERIOD_INT_PART_DEF,
   parameter int PERIOD_FRAC_PART = PERIOD_FRAC_PART_DEF,
   parameter int EDGE_FRAC_BITS   = EDGE_FRAC_BITS_DEF,
   parameter int AVG_SHIFT        = 4,
   parameter int MIN_EDGE_CYCLES  = 8
)(
   input  logic                                      CLK,
   input  logic                                      RESET_N,
   input  logic                                      CE,
   input  logic                                      EDGE_VALID,
   input  logic [EDGE_FRAC_BITS-1:0]                 EDGE_POS,
   output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_OUT,
   output logic                                      PERIOD_VALID,
   output logic                                      TIMEOUT
);

   // Free-running cycle counter width: one window of maximum periods plus a
   // spare bit so the window span is never ambiguous after wrap-around.
   localparam int c_cnt_w  = PERIOD_INT_PART + AVG_SHIFT + 1;
   localparam int c_ts_w   = c_cnt_w + EDGE_FRAC_BITS;
   // Fraction bits carried by the averaged difference
   localparam int c_fb     = EDGE_FRAC_BITS + AVG_SHIFT;
   // Unused low fraction bits of the output word
   localparam int c_pad    = PERIOD_FRAC_PART - c_fb;
   localparam int c_out_w  = PERIOD_INT_PART + PERIOD_FRAC_PART;
   localparam int c_fill_w = AVG_SHIFT + 1;
   localparam int c_depth  = 1 << AVG_SHIFT;

   localparam logic [c_fill_w-1:0]        c_fill_last = c_fill_w'(c_depth - 1);
   localparam logic [c_fill_w-1:0]        c_fill_full = c_fill_w'(c_depth);
   localparam logic [PERIOD_INT_PART-1:0] c_tmo_max   = '1;
   localparam logic [PERIOD_INT_PART-1:0] c_tmo_last  = c_tmo_max - 1'b1;

   meter_state_t               r_state;
   logic [c_cnt_w-1:0]         r_cycle_cnt;
   logic [PERIOD_INT_PART-1:0] r_tmo_cnt;
   logic [c_fill_w-1:0]        r_fill;

   logic [c_ts_w-1:0]          w_ts;
   logic [c_ts_w-1:0]          w_oldest;
   logic [c_ts_w-1:0]          w_diff;
   logic [c_out_w-1:0]         w_period;
   logic                       w_spacing_ok;
   logic                       w_accept;

   // ------------------------------------------------------------------------
   // Edge qualification
   // ------------------------------------------------------------------------
`ifdef PERIOD_METER_GLITCH_REJECT_EN
   // r_tmo_cnt holds (cycles since last accepted edge - 1) at the edge cycle
   localparam logic [PERIOD_INT_PART-1:0] c_min_gap =
      PERIOD_INT_PART'(MIN_EDGE_CYCLES - 1);

   // A timed-out meter has no previous edge, so nothing can be a glitch
   assign w_spacing_ok = TIMEOUT || (r_tmo_cnt >= c_min_gap);
`else
   // Every edge counts; the threshold term folds to a constant 1
   assign w_spacing_ok = 1'b1 | (MIN_EDGE_CYCLES < 0);
`endif

   assign w_accept = CE && EDGE_VALID && w_spacing_ok;

   // ------------------------------------------------------------------------
   // Timestamp ring and window arithmetic
   // ------------------------------------------------------------------------
   assign w_ts = {r_cycle_cnt, EDGE_POS};

   edge_timestamp_ring #(
      .TS_WIDTH   (c_ts_w),
      .DEPTH_LOG2 (AVG_SHIFT)
   ) u_ring (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .wr_en   (w_accept),
      .wr_data (w_ts),
      .oldest  (w_oldest)
   );

   // Modulo subtraction keeps the span correct across counter wrap-around
   assign w_diff = w_ts - w_oldest;

   // The span of one window is the sum of the averaged periods; dividing by
   // 2^AVG_SHIFT is just a reinterpretation of the binary point, so the low
   // bits are placed left-aligned in the fraction field. The timeout bounds
   // each period, so the top span bit stays clear; saturate if it ever set.
   always_comb begin
      w_period = c_out_w'(w_diff[PERIOD_INT_PART+c_fb-1:0]) << c_pad;
      if (w_diff[c_ts_w-1]) begin
         w_period = '1;
      end
   end

   // ------------------------------------------------------------------------
   // Free-running timestamp counter
   // ------------------------------------------------------------------------
   // Advances on every enabled cycle regardless of signal presence
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cycle_cnt <= '0;
      end else if (CE) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM, timeout counter and registered outputs
   // ------------------------------------------------------------------------
   // An accepted edge always wins over a timeout in the same cycle
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_IDLE;
         r_fill       <= '0;
         r_tmo_cnt    <= '0;
         PERIOD_OUT   <= '0;
         PERIOD_VALID <= 1'b0;
         TIMEOUT      <= 1'b1;
      end else if (CE) begin
         PERIOD_VALID <= 1'b0;
         if (w_accept) begin
            r_tmo_cnt <= '0;
            TIMEOUT   <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  r_fill  <= c_fill_w'(1);
                  r_state <= ST_FILL;
               end
               ST_FILL: begin
                  if (r_fill == c_fill_last) begin
                     r_fill  <= c_fill_full;
                     r_state <= ST_RUN;
                  end else begin
                     r_fill  <= r_fill + 1'b1;
                  end
               end
               ST_RUN: begin
                  PERIOD_OUT   <= w_period;
                  PERIOD_VALID <= 1'b1;
               end
               default: begin
                  r_fill  <= '0;
                  r_state <= ST_IDLE;
               end
            endcase
         end else if (r_tmo_cnt != c_tmo_max) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            // Signal lost: drop the window, keep the last period on the output
            if (r_tmo_cnt == c_tmo_last) begin
               TIMEOUT <= 1'b1;
               r_fill  <= '0;
               r_state <= ST_IDLE;
            end
         end
      end
   end

endmodule : period_meter
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_period_meter
//  Purpose  : Directed self-checking bench for period_meter (default params).
//  Revision : 1.0  initial release
// ============================================================================
module tb_period_meter;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        CE;
   logic        EDGE_VALID;
   logic [2:0]  EDGE_POS;
   logic [29:0] PERIOD_OUT;
   logic        PERIOD_VALID;
   logic        TIMEOUT;

   int n_checks = 0;
   int n_fail   = 0;

   period_meter dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .CE           (CE),
      .EDGE_VALID   (EDGE_VALID),
      .EDGE_POS     (EDGE_POS),
      .PERIOD_OUT   (PERIOD_OUT),
      .PERIOD_VALID (PERIOD_VALID),
      .TIMEOUT      (TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Edge arrives 'gap' enabled cycles after the previous one; outputs are
   // sampled on the negedge following the edge's sampling posedge.
   task automatic send_edge(input int gap, input int pos,
                            output logic pv, output logic [29:0] po);
      repeat (gap - 1) tick();
      EDGE_VALID = 1'b1;
      EDGE_POS   = 3'(pos);
      tick();
      pv = PERIOD_VALID;
      po = PERIOD_OUT;
      EDGE_VALID = 1'b0;
      EDGE_POS   = 3'd0;
   endtask

   initial begin
      logic        pv;
      logic [29:0] po;
      int          n_pv;
      int          t8;
      int          t8_prev;

      RESET_N    = 1'b0;
      CE         = 1'b1;
      EDGE_VALID = 1'b0;
      EDGE_POS   = 3'd0;
      repeat (3) tick();
      check("reset_period_out",   32'(PERIOD_OUT),   32'h0);
      check("reset_period_valid", 32'(PERIOD_VALID), 32'h0);
      check("reset_timeout",      32'(TIMEOUT),      32'h1);
      RESET_N = 1'b1;
      tick();

      // 16 steady edges fill the window, no output yet
      n_pv = 0;
      for (int i = 0; i < 16; i++) begin
         send_edge(100, 0, pv, po);
         n_pv += int'(pv);
         if (i == 0) check("first_edge_timeout_clear", 32'(TIMEOUT), 32'h0);
      end
      check("fill_no_valid", 32'(n_pv), 32'h0);
      send_edge(100, 0, pv, po);
      check("edge17_valid", 32'(pv), 32'h1);
      check("edge17_period", 32'(po), 32'h0640_0000);
      tick();
      check("valid_one_cycle", 32'(PERIOD_VALID), 32'h0);
      check("period_held", 32'(PERIOD_OUT), 32'h0640_0000);

      // Alternating 100/101 cycle periods average to 100.5
      for (int i = 0; i < 20; i++) begin
         send_edge((i % 2 == 1) ? 101 : 100, 0, pv, po);
      end
      check("alt_valid", 32'(pv), 32'h1);
      check("alt_period", 32'(po), 32'h0648_0000);

      // Period 100.125 cycles: edge position advances 1/8 per edge; the run
      // is long enough to wrap the 15-bit cycle counter.
      t8 = 0;
      for (int i = 0; i < 340; i++) begin
         t8_prev = t8;
         t8      = t8 + 801;
         send_edge((t8 >>> 3) - (t8_prev >>> 3), t8 & 7, pv, po);
         if (i >= 15) begin
            check("frac_valid", 32'(pv), 32'h1);
            check("frac_period", 32'(po), 32'h0642_0000);
         end
      end

      // Edges stop: timeout after 1023 cycles, period held
      repeat (1022) tick();
      check("timeout_not_yet", 32'(TIMEOUT), 32'h0);
      tick();
      check("timeout_set", 32'(TIMEOUT), 32'h1);
      check("timeout_period_held", 32'(PERIOD_OUT), 32'h0642_0000);
      check("timeout_no_valid", 32'(PERIOD_VALID), 32'h0);

      // Restart: 16 refill edges then a new result on the 17th
      n_pv = 0;
      for (int i = 0; i < 16; i++) begin
         send_edge(100, 0, pv, po);
         n_pv += int'(pv);
         if (i == 0) check("restart_timeout_clear", 32'(TIMEOUT), 32'h0);
      end
      check("refill_no_valid", 32'(n_pv), 32'h0);
      send_edge(100, 0, pv, po);
      check("restart_valid", 32'(pv), 32'h1);
      check("restart_period", 32'(po), 32'h0640_0000);

      // CE low freezes everything and masks edges
      repeat (40) tick();
      CE         = 1'b0;
      EDGE_VALID = 1'b1;
      n_pv       = 0;
      repeat (50) begin
         tick();
         n_pv += int'(PERIOD_VALID);
      end
      EDGE_VALID = 1'b0;
      CE         = 1'b1;
      check("ce_low_no_valid", 32'(n_pv), 32'h0);
      send_edge(60, 0, pv, po);
      check("ce_valid", 32'(pv), 32'h1);
      check("ce_period", 32'(po), 32'h0640_0000);

      // Extra edge 3 cycles after a valid one, then the next regular edge
      send_edge(3, 0, pv, po);
`ifdef PERIOD_METER_GLITCH_REJECT_EN
      check("glitch_valid", 32'(pv), 32'h0);
      check("glitch_period", 32'(po), 32'h0640_0000);
      send_edge(97, 0, pv, po);
      check("post_glitch_valid", 32'(pv), 32'h1);
      check("post_glitch_period", 32'(po), 32'h0640_0000);
`else
      check("glitch_valid", 32'(pv), 32'h1);
      check("glitch_period", 32'(po), 32'h05DF_0000);
      send_edge(97, 0, pv, po);
      check("post_glitch_valid", 32'(pv), 32'h1);
      check("post_glitch_period", 32'(po), 32'h05DC_0000);
`endif

      // Asynchronous reset in the middle of a cycle
      repeat (5) tick();
      #3;
      RESET_N = 1'b0;
      #1;
      check("async_rst_period_out",   32'(PERIOD_OUT),   32'h0);
      check("async_rst_period_valid", 32'(PERIOD_VALID), 32'h0);
      check("async_rst_timeout",      32'(TIMEOUT),      32'h1);
      tick();
      RESET_N = 1'b1;
      tick();
      send_edge(5, 0, pv, po);
      check("post_rst_timeout_clear", 32'(TIMEOUT), 32'h0);
      check("post_rst_no_valid", 32'(pv), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_period_meter
`default_nettype wire
